// File: rtl/booth_seq_divider.sv
// booth_seq_divider
//   Sequential signed integer divider using restoring division on operand
//   magnitudes, one quotient bit per clock, followed by a sign-correction
//   cycle. Latency is fixed at WIDTH+1 cycles from the accepting start edge
//   to the done pulse, including the divide-by-zero and overflow cases.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (aborts any operation)
//   start        request, sampled only while idle
//   dividend     signed dividend, sampled with start
//   divisor      signed divisor, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when results are loaded
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows the dividend
//   div_by_zero  divisor was zero (valid with done, held until next done)
//   overflow     most-negative / -1 (valid with done, held until next done)

module booth_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;          // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;      // raw dividend, returned on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  // Datapath helpers
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH-1:0] r_shift, q_shift;
  logic [WIDTH:0]   trial;

  // Negating the most-negative value yields 2^(WIDTH-1), which is exactly
  // the required magnitude when the result is read as unsigned.
  assign abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign q_shift = {q_q[WIDTH-2:0], 1'b0};
  // Both operands zero-extended, so the top bit is the borrow (trial < 0).
  assign trial   = {1'b0, r_shift} - {1'b0, dvs_q};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    r_d           = r_q;
    q_d           = q_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dbz_pend_d    = dbz_pend_q;
    ovf_pend_d    = ovf_pend_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d        = '0;
          q_d        = abs_dvd;
          dvs_d      = abs_dvs;
          dvd_d      = dividend;
          neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
          dbz_pend_d = (divisor == '0);
          ovf_pend_d = (dividend == MOST_NEG) && (divisor == '1);
          count_d    = CW'(WIDTH);
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end

      CALC: begin
        if (trial[WIDTH]) begin
          r_d = r_shift;
          q_d = q_shift;
        end else begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_shift[WIDTH-1:1], 1'b1};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Special cases still take the full latency; only the loaded
        // values differ from the normal sign-corrected result.
        if (dbz_pend_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else if (ovf_pend_q) begin
          quotient_d  = MOST_NEG;
          remainder_d = '0;
        end else begin
          quotient_d  = neg_quo_q ? -q_q : q_q;
          remainder_d = neg_rem_q ? -r_q : r_q;
        end
        div_by_zero_d = dbz_pend_q;
        overflow_d    = ovf_pend_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      r_q           <= '0;
      q_q           <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_pend_q    <= 1'b0;
      ovf_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      r_q           <= r_d;
      q_q           <= q_d;
      dvs_q         <= dvs_d;
      dvd_q         <= dvd_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dbz_pend_q    <= dbz_pend_d;
      ovf_pend_q    <= ovf_pend_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// tb_booth_seq_divider
//   Directed vector table, handshake corner sequences (back-to-back, start
//   held while busy, reset abort, flag hold), exhaustive and random operand
//   sweeps against an arithmetic reference model.

module tb_booth_seq_divider;

  localparam int W = 4;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, overflow;

  int checks = 0;
  int errors = 0;

  booth_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dbz;
    bit ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on integers, with the two special
  // cases defined by the divider's contract.
  function automatic void model(input int a, input int b, output int q,
                                output int r, output bit dbz, output bit ovf);
    int most_neg;
    most_neg = -(1 << (W - 1));
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      q = -1;
      r = a;
      dbz = 1'b1;
    end else if (a == most_neg && b == -1) begin
      q = most_neg;
      r = 0;
      ovf = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Bounded wait for done, sampling #1 after each rising edge.
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (!done && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cycles++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int a, input int b, input bit timing,
                        output int q, output int r, output bit dbz, output bit ovf);
    int n, bc;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (timing) chk("busy_after_start", int'(busy), 1);
    wait_done(n, bc);
    q   = sx(quotient);
    r   = sx(remainder);
    dbz = div_by_zero;
    ovf = overflow;
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d ovf=%0d cycles=%0d",
             a, b, q, r, dbz, ovf, n);
    if (timing) begin
      chk("latency", n, W + 1);
      chk("busy_cycles", bc + 1, W + 1);
      chk("busy_low_at_done", int'(busy), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic check_model(input int a, input int b, input int q, input int r,
                             input bit dbz, input bit ovf);
    int eq, er;
    bit edbz, eovf;
    model(a, b, eq, er, edbz, eovf);
    chk("model_quotient", q, eq);
    chk("model_remainder", r, er);
    chk("model_dbz", int'(dbz), int'(edbz));
    chk("model_ovf", int'(ovf), int'(eovf));
  endtask

  initial begin
    int q, r, n, bc, seen;
    bit dbz, ovf;

    vecs[0]  = '{ 7,  2,  3,  1, 1'b0, 1'b0};
    vecs[1]  = '{-7,  2, -3, -1, 1'b0, 1'b0};
    vecs[2]  = '{ 7, -2, -3,  1, 1'b0, 1'b0};
    vecs[3]  = '{-8,  3, -2, -2, 1'b0, 1'b0};
    vecs[4]  = '{-8, -1, -8,  0, 1'b0, 1'b1};
    vecs[5]  = '{ 5,  0, -1,  5, 1'b1, 1'b0};
    vecs[6]  = '{ 7,  7,  1,  0, 1'b0, 1'b0};
    vecs[7]  = '{-1,  5,  0, -1, 1'b0, 1'b0};
    vecs[8]  = '{ 3, -8,  0,  3, 1'b0, 1'b0};
    vecs[9]  = '{-8, -8,  1,  0, 1'b0, 1'b0};
    vecs[10] = '{-8,  1, -8,  0, 1'b0, 1'b0};
    vecs[11] = '{-6,  0, -1, -6, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    chk("reset_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; all with full timing checks
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b1, q, r, dbz, ovf);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
      chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
    end

    // Flags and results hold after done until the next operation
    run_op(-8, -1, 1'b0, q, r, dbz, ovf);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_ovf", int'(overflow), 1);
    chk("hold_quotient", sx(quotient), -8);
    run_op(4, 0, 1'b0, q, r, dbz, ovf);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_dbz", int'(div_by_zero), 1);
    chk("hold_remainder", sx(remainder), 4);
    run_op(6, 4, 1'b0, q, r, dbz, ovf);
    chk("clear_dbz", int'(dbz), 0);
    chk("clear_q", q, 1);

    // Back-to-back: start asserted in the done cycle
    @(negedge clk);
    dividend = W'(7);
    divisor  = W'(2);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, bc);
    chk("b2b_first_q", sx(quotient), 3);
    $display("op 7 / 2 -> q=%0d r=%0d (back-to-back first)", sx(quotient), sx(remainder));
    dividend = W'(-8);
    divisor  = W'(3);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    wait_done(n, bc);
    $display("op -8 / 3 -> q=%0d r=%0d cycles=%0d (back-to-back second)",
             sx(quotient), sx(remainder), n);
    chk("b2b_latency", n, W + 1);
    chk("b2b_second_q", sx(quotient), -2);
    chk("b2b_second_r", sx(remainder), -2);

    // start held through the whole operation with changed operands
    @(negedge clk);
    dividend = W'(7);
    divisor  = W'(2);
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = W'(5);
    divisor  = W'(3);
    wait_done(n, bc);
    start = 1'b0;
    $display("op 7 / 2 -> q=%0d r=%0d cycles=%0d (start held)", sx(quotient), sx(remainder), n);
    chk("held_latency", n, W + 1);
    chk("held_q", sx(quotient), 3);
    chk("held_r", sx(remainder), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("held_no_restart", seen, 0);

    // Reset during CALC step 2 aborts the operation
    @(negedge clk);
    dividend = W'(-7);
    divisor  = W'(2);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_flags", int'({div_by_zero, overflow}), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    $display("op -7 / 2 aborted by reset, done pulses afterwards=%0d", seen);
    chk("abort_no_done", seen, 0);
    run_op(-7, 2, 1'b1, q, r, dbz, ovf);
    chk("after_abort_q", q, -3);
    chk("after_abort_r", r, -1);

    // Exhaustive sweep against the reference model
    for (int a = -(1 << (W - 1)); a < (1 << (W - 1)); a++) begin
      for (int b = -(1 << (W - 1)); b < (1 << (W - 1)); b++) begin
        run_op(a, b, 1'b0, q, r, dbz, ovf);
        check_model(a, b, q, r, dbz, ovf);
      end
    end

    // Random operations, some with timing checks
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = sx(W'($urandom_range(0, (1 << W) - 1)));
      b = sx(W'($urandom_range(0, (1 << W) - 1)));
      run_op(a, b, (i % 4) == 0, q, r, dbz, ovf);
      check_model(a, b, q, r, dbz, ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
